// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: active-low row strobes, synchronized and debounced
// columns, one key_valid pulse per accepted press. Define KEYPAD_REPEAT_EN for auto-repeat.
module keypad_scan #(
    parameter int unsigned SETTLE_CYCLES   = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_CYCLES   = 64
) (
    input  logic       scan_clk,
    input  logic       rst,
    input  logic       col_3,
    input  logic       col_2,
    input  logic       col_1,
    input  logic       col_0,
    output logic       row_3,
    output logic       row_2,
    output logic       row_1,
    output logic       row_0,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int unsigned CntMax = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ?
                                     SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int unsigned CntW = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
    localparam logic [CntW-1:0] DebLast    = CntW'(DEBOUNCE_CYCLES - 1);

    if (SETTLE_CYCLES < 3) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 3");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("REPEAT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {StScan, StDebounce, StPressed, StHold} state_e;

    state_e          state_q;
    logic [3:0]      sync_q;
    logic [3:0]      cs_q;
    logic [3:0]      cap_q;
    logic [CntW-1:0] cnt_q;
    logic [1:0]      r_q;
    logic [1:0]      r_inc;
    logic [3:0]      row_q;
    logic [3:0]      key_code_q;
    logic            key_valid_q;
    logic            key_down_q;
    logic [3:0]      cols;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RptW = $clog2(REPEAT_CYCLES);
    localparam logic [RptW-1:0] RptLast = RptW'(REPEAT_CYCLES - 1);
    logic [RptW-1:0] rpt_q;
`endif

    assign cols  = {col_3, col_2, col_1, col_0};
    assign r_inc = r_q + 2'd1;

    function automatic logic [3:0] row_strobe(input logic [1:0] r);
        return ~(4'b0001 << r);
    endfunction

    // Lowest-numbered low column wins when several keys share a row.
    function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [3:0] c_n);
        logic [1:0] c;
        logic [3:0] code;
        c = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!c_n[i]) c = 2'(i);
        end
        case ({r, c})
            4'b00_00: code = 4'd1;
            4'b00_01: code = 4'd2;
            4'b00_10: code = 4'd3;
            4'b00_11: code = 4'd10;
            4'b01_00: code = 4'd4;
            4'b01_01: code = 4'd5;
            4'b01_10: code = 4'd6;
            4'b01_11: code = 4'd11;
            4'b10_00: code = 4'd7;
            4'b10_01: code = 4'd8;
            4'b10_10: code = 4'd9;
            4'b10_11: code = 4'd12;
            4'b11_00: code = 4'd14;
            4'b11_01: code = 4'd0;
            4'b11_10: code = 4'd15;
            default:  code = 4'd13;
        endcase
        return code;
    endfunction

    always_ff @(posedge scan_clk) begin
        if (rst) begin
            sync_q      <= 4'hF;
            cs_q        <= 4'hF;
            state_q     <= StScan;
            cap_q       <= 4'hF;
            cnt_q       <= '0;
            r_q         <= 2'd0;
            row_q       <= 4'b1110;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_q       <= '0;
`endif
        end else begin
            sync_q      <= cols;
            cs_q        <= sync_q;
            key_valid_q <= 1'b0;
            unique case (state_q)
                StScan: begin
                    if (cnt_q == SettleLast) begin
                        cnt_q <= '0;
                        if (cs_q == 4'hF) begin
                            r_q   <= r_inc;
                            row_q <= row_strobe(r_inc);
                        end else begin
                            cap_q   <= cs_q;
                            state_q <= StDebounce;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDebounce: begin
                    if (cs_q != cap_q) begin
                        state_q <= StScan;
                        cnt_q   <= '0;
                    end else if (cnt_q == DebLast) begin
                        state_q     <= StPressed;
                        cnt_q       <= '0;
                        key_code_q  <= key_lookup(r_q, cap_q);
                        key_valid_q <= 1'b1;
                        key_down_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StPressed: begin
                    state_q <= StHold;
                    cnt_q   <= '0;
`ifdef KEYPAD_REPEAT_EN
                    // The PRESSED cycle is the first of the first repeat period.
                    rpt_q   <= RptW'(1);
`endif
                end
                StHold: begin
                    if (cs_q == 4'hF) begin
                        if (cnt_q == DebLast) begin
                            key_down_q <= 1'b0;
                            r_q        <= r_inc;
                            row_q      <= row_strobe(r_inc);
                            state_q    <= StScan;
                            cnt_q      <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= '0;
                    end
`ifdef KEYPAD_REPEAT_EN
                    if (cs_q == cap_q) begin
                        if (rpt_q == RptLast) begin
                            rpt_q       <= '0;
                            key_valid_q <= 1'b1;
                        end else begin
                            rpt_q <= rpt_q + 1'b1;
                        end
                    end else begin
                        rpt_q <= '0;
                    end
`endif
                end
            endcase
        end
    end

    assign row_0     = row_q[0];
    assign row_1     = row_q[1];
    assign row_2     = row_q[2];
    assign row_3     = row_q[3];
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a behavioural key matrix drives the columns from the row strobes;
// expected key codes are queued on press and compared on every key_valid pulse.
module tb_keypad_scan;

    localparam int S = 4;
    localparam int D = 16;
    localparam int R = 64;

    logic        scan_clk = 1'b0;
    logic        rst;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] key_act;

    int n_pass  = 0;
    int n_total = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        int         row;
        int         col;
        logic [3:0] code;
    } vec_t;
    vec_t tbl[16];

    keypad_scan #(
        .SETTLE_CYCLES  (S),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_CYCLES  (R)
    ) dut (
        .scan_clk (scan_clk),
        .rst      (rst),
        .col_3    (cols[3]),
        .col_2    (cols[2]),
        .col_1    (cols[1]),
        .col_0    (cols[0]),
        .row_3    (rows[3]),
        .row_2    (rows[2]),
        .row_1    (rows[1]),
        .row_0    (rows[0]),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_down (key_down)
    );

    always #5 scan_clk = ~scan_clk;

    // Closed key pulls its column low while its row is strobed.
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (key_act[r*4+c] && !rows[r]) cols[c] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge scan_clk);
    endtask

    function automatic int row_idx();
        case (rows)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    // Scoreboard: every pulse must match the oldest queued code.
    always @(negedge scan_clk) begin
        if (!rst && key_valid) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pulse: got code %0d, expected no pulse (t=%0t)",
                         key_code, $time);
            end else begin
                check("pulse_code", key_code, exp_q.pop_front());
                check("pulse_down", key_down, 1);
            end
        end
    end

    task automatic wait_valid(input string name, input int bound);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge scan_clk);
            if (key_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, seen, 1);
    endtask

    task automatic wait_release(input string name, output int n);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge scan_clk);
            if (!key_down) begin
                n = i;
                break;
            end
        end
        if (n == 0) check(name, key_down, 0);
    endtask

    initial begin
        int n;
        int pulses;
        int last_t;
        tbl[0]  = '{0, 0, 4'd1};  tbl[1]  = '{0, 1, 4'd2};
        tbl[2]  = '{0, 2, 4'd3};  tbl[3]  = '{0, 3, 4'd10};
        tbl[4]  = '{1, 0, 4'd4};  tbl[5]  = '{1, 1, 4'd5};
        tbl[6]  = '{1, 2, 4'd6};  tbl[7]  = '{1, 3, 4'd11};
        tbl[8]  = '{2, 0, 4'd7};  tbl[9]  = '{2, 1, 4'd8};
        tbl[10] = '{2, 2, 4'd9};  tbl[11] = '{2, 3, 4'd12};
        tbl[12] = '{3, 0, 4'd14}; tbl[13] = '{3, 1, 4'd0};
        tbl[14] = '{3, 2, 4'd15}; tbl[15] = '{3, 3, 4'd13};

        key_act = '0;
        rst     = 1'b1;
        tick(2);
        check("reset_rows", rows, 4'b1110);
        check("reset_valid", key_valid, 0);
        check("reset_down", key_down, 0);
        check("reset_code", key_code, 0);
        rst = 1'b0;
        tick(S - 1);
        check("row0_settle", row_idx(), 0);
        tick(1);
        check("row1_after_settle", row_idx(), 1);

        // Key "1" held through reset: DEBOUNCE entry at the first terminal count.
        rst     = 1'b1;
        key_act = 16'h0001;
        tick(2);
        exp_q.push_back(4'd1);
        rst = 1'b0;
        tick(S + D - 1);
        check("latency_before", key_valid, 0);
        tick(1);
        check("latency_pulse", key_valid, 1);
        tick(1);
        check("latency_single", key_valid, 0);
        check("latency_down", key_down, 1);
        key_act = '0;
        wait_release("latency_release", n);

        // Every key once; release time and next scanned row.
        for (int i = 0; i < 16; i++) begin
            key_act = 16'(1) << (tbl[i].row * 4 + tbl[i].col);
            exp_q.push_back(tbl[i].code);
            wait_valid($sformatf("press_%0d", i), 200);
            key_act = '0;
            wait_release($sformatf("release_%0d", i), n);
            check($sformatf("release_time_%0d", i), (n >= D + 2 && n <= D + 3), 1);
            check($sformatf("next_row_%0d", i), row_idx(), (tbl[i].row + 1) % 4);
        end

        // Bouncing "*" must not be accepted; the stable press afterwards is.
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            key_act[12] = ~key_act[12];
            for (int k = 0; k < 5; k++) begin
                @(negedge scan_clk);
                if (key_valid) pulses++;
            end
        end
        check("bounce_no_pulse", pulses, 0);
        key_act[12] = 1'b1;
        exp_q.push_back(4'd14);
        wait_valid("bounce_accept", 200);
        key_act = '0;
        wait_release("bounce_release", n);

        // "4" and "6" together: lowest column wins, single pulse.
        key_act = 16'h0050;
        exp_q.push_back(4'd4);
        wait_valid("multi_press", 200);
        pulses = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge scan_clk);
            if (key_valid) pulses++;
        end
        check("multi_single", pulses, 0);
        key_act = '0;
        wait_release("multi_release", n);

        // Reset while "#" is held; the key is reported again afterwards.
        key_act = 16'h4000;
        exp_q.push_back(4'd15);
        wait_valid("hash_press", 200);
        tick(10);
        rst = 1'b1;
        tick(2);
        check("midhold_rows", rows, 4'b1110);
        check("midhold_valid", key_valid, 0);
        check("midhold_down", key_down, 0);
        check("midhold_code", key_code, 0);
        exp_q.push_back(4'd15);
        rst = 1'b0;
        wait_valid("hash_repress", 200);
        key_act = '0;
        wait_release("hash_release", n);

        // Hold "D" for 200 cycles after acceptance.
        key_act = 16'h8000;
        exp_q.push_back(4'd13);
`ifdef KEYPAD_REPEAT_EN
        repeat (3) exp_q.push_back(4'd13);
`endif
        wait_valid("d_press", 200);
        pulses = 1;
        last_t = 0;
        for (int k = 1; k < 200; k++) begin
            @(negedge scan_clk);
            if (key_valid) begin
                pulses++;
                check("repeat_gap", k - last_t, R);
                last_t = k;
            end
        end
`ifdef KEYPAD_REPEAT_EN
        check("repeat_count", pulses, 4);
`else
        check("repeat_count", pulses, 1);
`endif
        key_act = '0;
        wait_release("d_release", n);

        tick(4 * S);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
